xor_fold_arbiter: RTL and testbench

- Time-shares one 32->16 XOR-fold datapath (out[i] = in[i] ^ in[i+16]) between NREQ requester streams.
- Each requester sends a packet of DW-bit words over a valid/ready handshake.
- The block folds every beat and XOR-accumulates the folded results over the packet. It emits one 16-bit signature per packet, tagged with the requester id.
- Sits between the per-channel word sources (the a/b channels) and the signature consumer.

---
 rtl/xor_fold_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_xor_fold_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_fold_arbiter.sv
// Purpose : round-robin arbiter that time-shares one DW->DW/2 XOR-fold datapath
//           between NREQ packet streams and emits one folded signature per packet.
// Latency : single-beat packet: valid seen in IDLE at cycle 0, beat accepted at
//           cycle 1, out_valid at cycle 2; next arbitration the cycle after the
//           output handshake.
// Backpressure: one packet in flight. req_ready is held low in IDLE and OUT. The
//           signature, its id and out_valid stay registered and stable until
//           out_ready is seen.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready[NREQ]   per-requester beat handshake
//   req_data[NREQ*DW]           requester k on bits [k*DW +: DW]
//   req_last[NREQ]              final beat of a packet
//   out_valid/out_ready         signature handshake
//   out_data[OW], out_id[IDW]   packet signature and owning requester
//   out_beats[8]                accepted beats of the packet, saturating at 255
//                               (present only when XOR_FOLD_BEAT_CNT_EN is defined)
// Optional feature macro: XOR_FOLD_BEAT_CNT_EN

module xor_fold_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    localparam int OW  = DW / 2,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OW-1:0]      out_data,
`ifdef XOR_FOLD_BEAT_CNT_EN
    output logic [7:0]         out_beats,
`endif
    output logic [IDW-1:0]     out_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [OW-1:0]  acc_q, acc_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           out_valid_q, out_valid_d;
    logic [OW-1:0]  out_data_q, out_data_d;
    logic [IDW-1:0] out_id_q, out_id_d;

`ifdef XOR_FOLD_BEAT_CNT_EN
    logic [7:0]     beat_cnt_q, beat_cnt_d;
    logic [7:0]     out_beats_q, out_beats_d;
    logic [7:0]     beat_cnt_inc;
`endif

    logic [IDW-1:0] pick_idx;
    logic [DW-1:0]  gnt_data;
    logic [OW-1:0]  acc_next;

    function automatic logic [OW-1:0] fold(input logic [DW-1:0] w);
        return w[OW-1:0] ^ w[DW-1:OW];
    endfunction

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int   idx;
        logic found;
        pick_idx = rr_ptr_q;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NREQ;
            if (!found && req_valid[IDW'(idx)]) begin
                found    = 1'b1;
                pick_idx = IDW'(idx);
            end
        end
    end

    // Constant-index mux so that only the granted lane reaches the fold; X on
    // other lanes cannot leak into the accumulator.
    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_q == IDW'(k)) begin
                gnt_data = req_data[k*DW +: DW];
            end
        end
    end

    assign acc_next = acc_q ^ fold(gnt_data);

`ifdef XOR_FOLD_BEAT_CNT_EN
    assign beat_cnt_inc = (beat_cnt_q == 8'hFF) ? 8'hFF : beat_cnt_q + 8'd1;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        req_ready   = '0;
`ifdef XOR_FOLD_BEAT_CNT_EN
        beat_cnt_d  = beat_cnt_q;
        out_beats_d = out_beats_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = pick_idx;
                    acc_d   = '0;
                    state_d = ACCUM;
`ifdef XOR_FOLD_BEAT_CNT_EN
                    beat_cnt_d = 8'd0;
`endif
                end
            end
            ACCUM: begin
                req_ready[grant_q] = 1'b1;
                // req_last only counts alongside a valid beat.
                if (req_valid[grant_q]) begin
                    acc_d = acc_next;
`ifdef XOR_FOLD_BEAT_CNT_EN
                    beat_cnt_d = beat_cnt_inc;
`endif
                    if (req_last[grant_q]) begin
                        state_d     = OUT;
                        out_valid_d = 1'b1;
                        out_data_d  = acc_next;
                        out_id_d    = grant_q;
`ifdef XOR_FOLD_BEAT_CNT_EN
                        out_beats_d = beat_cnt_inc;
`endif
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    rr_ptr_d    = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
`ifdef XOR_FOLD_BEAT_CNT_EN
            beat_cnt_q  <= 8'd0;
            out_beats_q <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
`ifdef XOR_FOLD_BEAT_CNT_EN
            beat_cnt_q  <= beat_cnt_d;
            out_beats_q <= out_beats_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
`ifdef XOR_FOLD_BEAT_CNT_EN
    assign out_beats = out_beats_q;
`endif

endmodule

// File: tb/tb_xor_fold_arbiter.sv
// Purpose : self-checking bench for xor_fold_arbiter (NREQ=2, DW=32).
// Latency : checks the cycle-0/1/2 single-beat timing explicitly.
// Backpressure: exercises out_ready stalls, mid-packet valid gaps and reset mid-packet.

module tb_xor_fold_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 32;

    typedef struct packed {
        logic [0:0]  id;
        logic [15:0] data;
        logic [7:0]  beats;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        out_data;
    logic [0:0]         out_id;
`ifdef XOR_FOLD_BEAT_CNT_EN
    logic [7:0]         out_beats;
`endif

    int   checks = 0;
    int   errors = 0;
    logic rr_chk = 1'b0;
    exp_t sb[$];

    xor_fold_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_last  (req_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef XOR_FOLD_BEAT_CNT_EN
        .out_beats (out_beats),
`endif
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] fold(input logic [31:0] w);
        return w[15:0] ^ w[31:16];
    endfunction

    function automatic exp_t mk(input int id, input logic [15:0] d, input int beats);
        exp_t e;
        e.id    = 1'(id);
        e.data  = d;
        e.beats = 8'(beats);
        return e;
    endfunction

    // Drive one beat on requester k and hold it until accepted; called just after a posedge.
    task automatic send_beat(input int k, input logic [31:0] d, input logic l);
        int n;
        n = 0;
        req_valid[k] = 1'b1;
        req_data[k*DW +: DW] = d;
        req_last[k] = l;
        forever begin
            @(negedge clk);
            if (req_ready[k]) break;
            n++;
            if (n > 200) begin
                chk("beat_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_last[k]  = 1'b0;
        req_data[k*DW +: DW] = 'x;
    endtask

    // Scoreboard: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_data", 32'(out_data), 32'(e.data));
                chk("sb_id", 32'(out_id), 32'(e.id));
`ifdef XOR_FOLD_BEAT_CNT_EN
                chk("sb_beats", 32'(out_beats), 32'(e.beats));
`endif
            end
        end
        if (rr_chk) chk("rdy_onehot", 32'($countones(req_ready) <= 1), 1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = 'x;
        out_ready = 1'b1;
        #1;
        chk("rst_rdy", 32'(req_ready), 0);
        chk("rst_vld", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_id", 32'(out_id), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-beat latency on req0.
        @(posedge clk);
        #1;
        sb.push_back(mk(0, 16'h444C, 1));
        req_valid[0] = 1'b1;
        req_data[31:0] = 32'h1234_5678;
        req_last[0] = 1'b1;
        @(negedge clk);
        chk("lat_c0_rdy", 32'(req_ready), 0);
        @(negedge clk);
        chk("lat_c1_rdy", 32'(req_ready), 32'b01);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        req_last[0]  = 1'b0;
        req_data[31:0] = 'x;
        @(negedge clk);
        chk("lat_c2_vld", 32'(out_valid), 1);
        @(negedge clk);
        chk("lat_c3_vld", 32'(out_valid), 0);

        // Two-beat packet on req1.
        @(posedge clk);
        #1;
        sb.push_back(mk(1, 16'hBBB3, 2));
        send_beat(1, 32'h1234_5678, 1'b0);
        send_beat(1, 32'hFFFF_0000, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Round-robin with both requesters continuously valid.
        sb.push_back(mk(0, fold(32'hA000_0001), 1));
        sb.push_back(mk(1, fold(32'hB000_0002), 1));
        sb.push_back(mk(0, fold(32'hC000_0003), 1));
        sb.push_back(mk(1, fold(32'hD000_0004), 1));
        rr_chk = 1'b1;
        fork
            begin
                send_beat(0, 32'hA000_0001, 1'b1);
                send_beat(0, 32'hC000_0003, 1'b1);
            end
            begin
                send_beat(1, 32'hB000_0002, 1'b1);
                send_beat(1, 32'hD000_0004, 1'b1);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        rr_chk = 1'b0;

        // Output backpressure with req1 waiting.
        out_ready = 1'b0;
        sb.push_back(mk(0, fold(32'hA5A5_0F0F), 1));
        sb.push_back(mk(1, fold(32'h1357_9BDF), 1));
        fork
            send_beat(0, 32'hA5A5_0F0F, 1'b1);
            send_beat(1, 32'h1357_9BDF, 1'b1);
            begin
                int n;
                n = 0;
                while (!out_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_seen", 32'(out_valid), 1);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_vld", 32'(out_valid), 1);
                    chk("bp_data", 32'(out_data), 32'(fold(32'hA5A5_0F0F)));
                    chk("bp_id", 32'(out_id), 0);
                    chk("bp_rdy", 32'(req_ready), 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Grant lock: req0 gaps mid-packet (last without valid) while req1 waits.
        sb.push_back(mk(0, fold(32'h0F0F_1111) ^ fold(32'h2222_F0F0), 2));
        sb.push_back(mk(1, fold(32'h7777_8888), 1));
        fork
            begin
                send_beat(0, 32'h0F0F_1111, 1'b0);
                req_last[0] = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("lock_rdy", 32'(req_ready), 32'b01);
                    chk("lock_vld", 32'(out_valid), 0);
                end
                @(posedge clk);
                #1;
                send_beat(0, 32'h2222_F0F0, 1'b1);
            end
            send_beat(1, 32'h7777_8888, 1'b1);
        join
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-packet: first beat of a two-beat packet then asynchronous reset.
        send_beat(0, 32'hDEAD_BEEF, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_rdy", 32'(req_ready), 0);
        chk("mrst_vld", 32'(out_valid), 0);
        chk("mrst_data", 32'(out_data), 0);
        chk("mrst_id", 32'(out_id), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(mk(1, 16'hFFFF, 1));
        send_beat(1, 32'hFFFF_0000, 1'b1);

        begin
            int n;
            n = 0;
            while (sb.size() != 0 && n < 200) begin
                @(posedge clk);
                n++;
            end
        end
        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
